// File: rtl/pad_attr_pkg.sv
// rtl/pad_attr_pkg.sv - shared constants, FSM encodings and WARL mask helper for pad_attr_sequencer
//
// Purpose: default pad counts and index width, sweep FSM state encodings,
//          and attr_mask(), which picks the MIO or DIO implemented-bit mask
//          for a pad index.
// Ports:   none (package)
package pad_attr_pkg;

  localparam int NMioPadsDef = 32;
  localparam int NDioPadsDef = 15;
  localparam int NPads       = NMioPadsDef + NDioPadsDef;
  localparam int IdxW        = $clog2(NPads);

  // Sweep FSM encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StApply = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  // Pads below n_mio are MIO pads, everything above is DIO.
  // Masks are passed in so that parameter overrides on the top are honoured.
  function automatic logic [31:0] attr_mask(input logic [31:0] idx,
                                            input logic [31:0] n_mio,
                                            input logic [31:0] mio_mask,
                                            input logic [31:0] dio_mask);
    return (idx < n_mio) ? mio_mask : dio_mask;
  endfunction

endpackage

// File: rtl/pad_attr_sequencer.sv
// rtl/pad_attr_sequencer.sv - staged/active pad attribute registers with SSN-friendly commit sweep
//
// Purpose: software writes a staged copy of every pad attribute; a commit
//          walks the pads and copies staged to active one pad per step,
//          holding StepCycles cycles on each pad that actually changes.
//          A sticky lock freezes the staged copy.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_valid_i/req_ready_o       request handshake (ready only while idle)
//   req_write_i, req_idx_i,
//   req_wdata_i                   request command, pad index, write data
//   lock_i, commit_i              lock pulse, commit pulse
//   rsp_valid_o, rsp_rdata_o,
//   rsp_err_o                     one-cycle response, staged value, error
//   locked_o, busy_o, done_o      lock state, sweep active, sweep-done pulse
//   mio_attr_o, dio_attr_o        flattened active attributes
module pad_attr_sequencer
  import pad_attr_pkg::*;
#(
  parameter int               NMioPads    = 32,
  parameter int               NDioPads    = 15,
  parameter int               AttrDw      = 10,
  parameter logic [AttrDw-1:0] MioWarlMask = 10'h3FF,
  parameter logic [AttrDw-1:0] DioWarlMask = 10'h3FF,
  parameter int               StepCycles  = 4,
  localparam int              NumPads     = NMioPads + NDioPads,
  localparam int              PadIdxW     = $clog2(NumPads)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [PadIdxW-1:0]           req_idx_i,
  input  logic [AttrDw-1:0]            req_wdata_i,
  input  logic                         lock_i,
  input  logic                         commit_i,
  output logic                         rsp_valid_o,
  output logic [AttrDw-1:0]            rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         locked_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NMioPads*AttrDw-1:0]   mio_attr_o,
  output logic [NDioPads*AttrDw-1:0]   dio_attr_o
);

  localparam int CntW = $clog2(StepCycles + 1);

  logic [AttrDw-1:0]  staged_q [NumPads];
  logic [AttrDw-1:0]  active_q [NumPads];

  logic [1:0]         state_q, state_d;
  logic [PadIdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               locked_q, locked_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [AttrDw-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               done_q, done_d;

  logic               accept;
  logic               idx_ok;
  logic               wr_en;
  logic [31:0]        mask_full;
  logic [AttrDw-1:0]  wr_val;
  logic               apply_en;
  logic               advance;

  assign req_ready_o = (state_q == StIdle);

  // Request decode and response
  always_comb begin
    accept      = req_valid_i && req_ready_o;
    idx_ok      = (32'(req_idx_i) < 32'(NumPads));
    mask_full   = attr_mask(32'(req_idx_i), 32'(NMioPads),
                            32'(MioWarlMask), 32'(DioWarlMask));
    wr_val      = req_wdata_i & mask_full[AttrDw-1:0];
    // Lock takes effect on the next edge, so locked_q (not lock_i) gates writes
    wr_en       = accept && req_write_i && idx_ok && !locked_q;
    locked_d    = locked_q | lock_i;
    rsp_valid_d = accept;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      if (!idx_ok) begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end else if (req_write_i && !locked_q) begin
        rsp_rdata_d = wr_val;
        rsp_err_d   = 1'b0;
      end else begin
        rsp_rdata_d = staged_q[req_idx_i];
        rsp_err_d   = req_write_i;
      end
    end
  end

  // Sweep FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    apply_en  = 1'b0;
    advance   = 1'b0;

    case (state_q)
      StIdle: begin
        if (commit_i) begin
          state_d = StApply;
          ptr_d   = '0;
        end
      end
      StApply: begin
        if (staged_q[ptr_q] != active_q[ptr_q]) begin
          apply_en = 1'b1;
          if (StepCycles > 1) begin
            state_d = StHold;
            cnt_d   = CntW'(StepCycles - 1);
          end else begin
            advance = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(1)) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && commit_i) begin
      pending_d = 1'b1;
    end

    if (advance) begin
      if (ptr_q == PadIdxW'(NumPads - 1)) begin
        done_d    = 1'b1;
        ptr_d     = '0;
        // A commit on the very last cycle counts as pending too
        state_d   = (pending_q || commit_i) ? StApply : StIdle;
        pending_d = 1'b0;
      end else begin
        ptr_d   = ptr_q + PadIdxW'(1);
        state_d = StApply;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      locked_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NumPads; i++) begin
        staged_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      locked_q    <= locked_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      done_q      <= done_d;
      if (wr_en) begin
        staged_q[req_idx_i] <= wr_val;
      end
      if (apply_en) begin
        active_q[ptr_q] <= staged_q[ptr_q];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign locked_o    = locked_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;

  for (genvar k = 0; k < NMioPads; k++) begin : g_mio
    assign mio_attr_o[k*AttrDw +: AttrDw] = active_q[k];
  end
  for (genvar k = 0; k < NDioPads; k++) begin : g_dio
    assign dio_attr_o[k*AttrDw +: AttrDw] = active_q[NMioPads + k];
  end

endmodule
